// File: rtl/transducer_pkg.sv
// Shared types and default widths for the multi-channel transducer firing block.
//   fire_state_t : global arm/fire sequencer states
//   chan_state_t : per-channel pulse sequencer states
//   DEF_*        : default parameter values used by the top level
package transducer_pkg;

  localparam int DEF_N_CH   = 8;
  localparam int DEF_PD_W   = 16;
  localparam int DEF_CT_W   = 9;
  localparam int DEF_NP_W   = 4;
  localparam int DEF_MAX_ON = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FIRING,
    ST_DONE,
    ST_FAULT
  } fire_state_t;

  typedef enum logic [1:0] {
    WAIT_PD,
    ON,
    OFF,
    FIN
  } chan_state_t;

endpackage

// File: rtl/transducer_channel.sv
// One transducer channel: latched configuration, phase-delay / charge / off-gap /
// pulse down-counters, and an on-time watchdog with a sticky trip flag.
// Ports:
//   clk_i       system clock
//   clear_i     return sequencer to rest, drive low (reset or leaving FIRING)
//   trip_clr_i  clear the sticky watchdog trip (reset or block disabled)
//   latch_i     capture configuration inputs (arm edge)
//   start_i     begin the phase-delay countdown (fire edge)
//   en_i, pd_i, ct_i, np_i, off_i  configuration captured on latch_i
//   drive_o     registered pulser drive
//   fin_o       channel has completed its burst
//   trip_o      sticky watchdog trip
module transducer_channel
  import transducer_pkg::*;
#(
  parameter int PD_W   = DEF_PD_W,
  parameter int CT_W   = DEF_CT_W,
  parameter int NP_W   = DEF_NP_W,
  parameter int MAX_ON = DEF_MAX_ON
) (
  input  logic            clk_i,
  input  logic            clear_i,
  input  logic            trip_clr_i,
  input  logic            latch_i,
  input  logic            start_i,
  input  logic            en_i,
  input  logic [PD_W-1:0] pd_i,
  input  logic [CT_W-1:0] ct_i,
  input  logic [NP_W-1:0] np_i,
  input  logic [CT_W-1:0] off_i,
  output logic            drive_o,
  output logic            fin_o,
  output logic            trip_o
);

  localparam int WD_W = $clog2(MAX_ON + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_ON);

  // Latched configuration (data only, no reset)
  logic            en_q;
  logic [PD_W-1:0] pd_q;
  logic [CT_W-1:0] ct_q;
  logic [NP_W-1:0] np_q;
  logic [CT_W-1:0] off_q;

  // Sequencer state
  chan_state_t     st_q, st_d;
  logic [PD_W-1:0] pd_cnt_q, pd_cnt_d;
  logic [CT_W-1:0] ct_cnt_q, ct_cnt_d;
  logic [CT_W-1:0] off_cnt_q, off_cnt_d;
  logic [NP_W-1:0] pulse_q, pulse_d;
  logic            drive_q, drive_d;
  logic            fin_q, fin_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            trip_q, trip_d;

  function automatic logic [PD_W-1:0] dec_pd(input logic [PD_W-1:0] x);
    return (x == '0) ? '0 : x - PD_W'(1);
  endfunction

  function automatic logic [CT_W-1:0] dec_ct(input logic [CT_W-1:0] x);
    return (x == '0) ? '0 : x - CT_W'(1);
  endfunction

  function automatic logic [NP_W-1:0] dec_np(input logic [NP_W-1:0] x);
    return (x == '0) ? '0 : x - NP_W'(1);
  endfunction

  function automatic logic [WD_W-1:0] inc_wd(input logic [WD_W-1:0] x);
    return (x >= WD_MAX) ? x : x + WD_W'(1);
  endfunction

  // Configuration capture; a pulse count of 0 behaves as a single pulse
  always_ff @(posedge clk_i) begin
    if (latch_i) begin
      en_q  <= en_i;
      pd_q  <= pd_i;
      ct_q  <= ct_i;
      np_q  <= (np_i == '0) ? NP_W'(1) : np_i;
      off_q <= off_i;
    end
  end

  // Counters hold "cycles remaining after this one", so every transition is
  // taken on the edge where the counter is already zero.
  always_comb begin
    st_d      = st_q;
    pd_cnt_d  = pd_cnt_q;
    ct_cnt_d  = ct_cnt_q;
    off_cnt_d = off_cnt_q;
    pulse_d   = pulse_q;
    drive_d   = drive_q;
    fin_d     = fin_q;

    if (start_i) begin
      st_d     = WAIT_PD;
      pd_cnt_d = pd_q;
      pulse_d  = np_q;
      drive_d  = 1'b0;
      fin_d    = 1'b0;
    end else begin
      case (st_q)
        WAIT_PD: begin
          if (!en_q) begin
            st_d  = FIN;
            fin_d = 1'b1;
          end else if (pd_cnt_q != '0) begin
            pd_cnt_d = dec_pd(pd_cnt_q);
          end else if (ct_q == '0) begin
            st_d  = FIN;
            fin_d = 1'b1;
          end else begin
            st_d     = ON;
            drive_d  = 1'b1;
            ct_cnt_d = dec_ct(ct_q);
          end
        end
        ON: begin
          if (ct_cnt_q != '0) begin
            ct_cnt_d = dec_ct(ct_cnt_q);
          end else if (pulse_q <= NP_W'(1)) begin
            st_d    = FIN;
            drive_d = 1'b0;
            fin_d   = 1'b1;
            pulse_d = '0;
          end else begin
            pulse_d = dec_np(pulse_q);
            if (off_q == '0) begin
              // Zero gap: next pulse starts immediately, drive stays high
              ct_cnt_d = dec_ct(ct_q);
            end else begin
              st_d      = OFF;
              drive_d   = 1'b0;
              off_cnt_d = dec_ct(off_q);
            end
          end
        end
        OFF: begin
          if (off_cnt_q != '0) begin
            off_cnt_d = dec_ct(off_cnt_q);
          end else begin
            st_d     = ON;
            drive_d  = 1'b1;
            ct_cnt_d = dec_ct(ct_q);
          end
        end
        default: begin
          st_d = FIN;
        end
      endcase
    end

    if (clear_i) begin
      st_d    = FIN;
      drive_d = 1'b0;
      fin_d   = 1'b0;
      pulse_d = '0;
    end
  end

  // Watchdog counts the high cycle being entered, so the trip flag rises on
  // the same edge that starts the MAX_ON-th consecutive high cycle.
  always_comb begin
    wd_d = drive_d ? inc_wd(wd_q) : '0;
    if (trip_clr_i) begin
      trip_d = 1'b0;
    end else begin
      trip_d = trip_q | (wd_d >= WD_MAX);
    end
  end

  always_ff @(posedge clk_i) begin
    st_q      <= st_d;
    pd_cnt_q  <= pd_cnt_d;
    ct_cnt_q  <= ct_cnt_d;
    off_cnt_q <= off_cnt_d;
    pulse_q   <= pulse_d;
    drive_q   <= drive_d;
    fin_q     <= fin_d;
    wd_q      <= wd_d;
    trip_q    <= trip_d;
  end

  assign drive_o = drive_q;
  assign fin_o   = fin_q;
  assign trip_o  = trip_q;

endmodule

// File: rtl/transducer_array_fire.sv
// Multi-channel burst transducer driver. Arms (latching per-channel config),
// fires all enabled channels from one common edge, and stops everything on
// abort, block disable or any channel's on-time watchdog trip.
// Ports:
//   clk, rst (sync, active-high), isActive (block enable)
//   onYourMark (arm), GOGOGO_EXCLAMATION (fire, only with onYourMark)
//   chanEnable, phaseDelay, chargeTime, pulseCount, offTime  configuration
//   transducerOutput  per-channel pulser drive
//   fireComplete      burst finished, fault, or block not active
//   warning           sticky per-channel watchdog trip
//   busy              armed or firing
module transducer_array_fire
  import transducer_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int PD_W   = DEF_PD_W,
  parameter int CT_W   = DEF_CT_W,
  parameter int NP_W   = DEF_NP_W,
  parameter int MAX_ON = DEF_MAX_ON
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 isActive,
  input  logic                 onYourMark,
  input  logic                 GOGOGO_EXCLAMATION,
  input  logic [N_CH-1:0]      chanEnable,
  input  logic [N_CH*PD_W-1:0] phaseDelay,
  input  logic [N_CH*CT_W-1:0] chargeTime,
  input  logic [NP_W-1:0]      pulseCount,
  input  logic [CT_W-1:0]      offTime,
  output logic [N_CH-1:0]      transducerOutput,
  output logic                 fireComplete,
  output logic [N_CH-1:0]      warning,
  output logic                 busy
);

  fire_state_t state_q, state_d;
  logic        fire_complete_q, fire_complete_d;
  logic        busy_q, busy_d;

  logic [N_CH-1:0] drive;
  logic [N_CH-1:0] fin;
  logic [N_CH-1:0] trip;
  logic            all_fin;
  logic            any_trip;
  logic            latch;
  logic            start;
  logic            chan_clear;
  logic            trip_clr;

  assign all_fin  = &fin;
  assign any_trip = |trip;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      fire_complete_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      fire_complete_q <= fire_complete_d;
      busy_q          <= busy_d;
    end
  end

  // Next-state logic: disable beats a trip, a trip beats everything else
  always_comb begin
    state_d = state_q;
    if (!isActive) begin
      state_d = ST_IDLE;
    end else if (any_trip) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (onYourMark && !GOGOGO_EXCLAMATION) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (onYourMark && GOGOGO_EXCLAMATION) state_d = ST_FIRING;
        end
        ST_FIRING: begin
          if (!onYourMark || !GOGOGO_EXCLAMATION) state_d = ST_IDLE;
          else if (all_fin)                       state_d = ST_DONE;
        end
        ST_DONE: begin
          if (!onYourMark && !GOGOGO_EXCLAMATION) state_d = ST_IDLE;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output logic (registered in the state register above)
  always_comb begin
    fire_complete_d = !isActive || (state_d == ST_DONE) || (state_d == ST_FAULT);
    busy_d          = (state_d == ST_ARMED) || (state_d == ST_FIRING);
  end

  // Channel control strobes. Channels only run while the next state is
  // FIRING, so abort, fault, disable and completion all zero the drive on
  // the same edge the sequencer leaves FIRING.
  assign latch      = !rst && (state_q == ST_IDLE)  && (state_d == ST_ARMED);
  assign start      = !rst && (state_q == ST_ARMED) && (state_d == ST_FIRING);
  assign chan_clear = rst || (state_d != ST_FIRING);
  assign trip_clr   = rst || !isActive;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    transducer_channel #(
      .PD_W  (PD_W),
      .CT_W  (CT_W),
      .NP_W  (NP_W),
      .MAX_ON(MAX_ON)
    ) u_ch (
      .clk_i     (clk),
      .clear_i   (chan_clear),
      .trip_clr_i(trip_clr),
      .latch_i   (latch),
      .start_i   (start),
      .en_i      (chanEnable[g]),
      .pd_i      (phaseDelay[g*PD_W +: PD_W]),
      .ct_i      (chargeTime[g*CT_W +: CT_W]),
      .np_i      (pulseCount),
      .off_i     (offTime),
      .drive_o   (drive[g]),
      .fin_o     (fin[g]),
      .trip_o    (trip[g])
    );
  end

  assign transducerOutput = drive;
  assign fireComplete     = fire_complete_q;
  assign warning          = trip;
  assign busy             = busy_q;

endmodule

// File: tb/tb_transducer_array_fire.sv
// Directed self-checking bench for transducer_array_fire (4 channels, MAX_ON=8).
module tb_transducer_array_fire;

  localparam int N_CH   = 4;
  localparam int PD_W   = 16;
  localparam int CT_W   = 9;
  localparam int NP_W   = 4;
  localparam int MAX_ON = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 isActive;
  logic                 onYourMark;
  logic                 GOGOGO_EXCLAMATION;
  logic [N_CH-1:0]      chanEnable;
  logic [N_CH*PD_W-1:0] phaseDelay;
  logic [N_CH*CT_W-1:0] chargeTime;
  logic [NP_W-1:0]      pulseCount;
  logic [CT_W-1:0]      offTime;
  logic [N_CH-1:0]      transducerOutput;
  logic                 fireComplete;
  logic [N_CH-1:0]      warning;
  logic                 busy;

  transducer_array_fire #(
    .N_CH(N_CH), .PD_W(PD_W), .CT_W(CT_W), .NP_W(NP_W), .MAX_ON(MAX_ON)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .isActive          (isActive),
    .onYourMark        (onYourMark),
    .GOGOGO_EXCLAMATION(GOGOGO_EXCLAMATION),
    .chanEnable        (chanEnable),
    .phaseDelay        (phaseDelay),
    .chargeTime        (chargeTime),
    .pulseCount        (pulseCount),
    .offTime           (offTime),
    .transducerOutput  (transducerOutput),
    .fireComplete      (fireComplete),
    .warning           (warning),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int              cfg_pd [N_CH];
  int              cfg_ct [N_CH];
  logic [N_CH-1:0] cfg_en;
  int              cfg_np;
  int              cfg_off;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected drive for cycle t after the fire edge: pulse p of channel i is
  // high on t = P+1+p*(C+O) .. P+p*(C+O)+C
  function automatic logic [N_CH-1:0] exp_out(input int t);
    logic [N_CH-1:0] r;
    int n, s;
    r = '0;
    n = (cfg_np == 0) ? 1 : cfg_np;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_en[i]) begin
        for (int p = 0; p < n; p++) begin
          s = cfg_pd[i] + 1 + p * (cfg_ct[i] + cfg_off);
          if (t >= s && t < s + cfg_ct[i]) r[i] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic apply_cfg();
    for (int i = 0; i < N_CH; i++) begin
      phaseDelay[i*PD_W +: PD_W] = PD_W'(cfg_pd[i]);
      chargeTime[i*CT_W +: CT_W] = CT_W'(cfg_ct[i]);
    end
    chanEnable = cfg_en;
    pulseCount = NP_W'(cfg_np);
    offTime    = CT_W'(cfg_off);
  endtask

  task automatic set_cfg(input int pd0, ct0, pd1, ct1, pd2, ct2, pd3, ct3,
                         input logic [N_CH-1:0] en, input int np, input int off);
    cfg_pd[0] = pd0; cfg_ct[0] = ct0;
    cfg_pd[1] = pd1; cfg_ct[1] = ct1;
    cfg_pd[2] = pd2; cfg_ct[2] = ct2;
    cfg_pd[3] = pd3; cfg_ct[3] = ct3;
    cfg_en  = en;
    cfg_np  = np;
    cfg_off = off;
  endtask

  task automatic arm_and_fire();
    apply_cfg();
    onYourMark = 1'b1; GOGOGO_EXCLAMATION = 1'b0;
    tick();
    GOGOGO_EXCLAMATION = 1'b1;
    tick();
  endtask

  task automatic check_all(input string tag, input logic [N_CH-1:0] out,
                           input logic fc, input logic [N_CH-1:0] w, input logic b);
    check_eq({tag, " out"},  32'(transducerOutput), 32'(out));
    check_eq({tag, " fc"},   32'(fireComplete),     32'(fc));
    check_eq({tag, " warn"}, 32'(warning),          32'(w));
    check_eq({tag, " busy"}, 32'(busy),             32'(b));
  endtask

  // Full arm/fire/complete/release sequence against the cfg_* vectors.
  // scramble changes every config input while armed; timing must not move.
  task automatic run_fire(input string name, input int ncyc, input int done_at, input bit scramble);
    apply_cfg();
    onYourMark = 1'b1; GOGOGO_EXCLAMATION = 1'b0;
    tick();
    check_eq({name, " armed busy"}, 32'(busy), 32'd1);
    check_eq({name, " armed fc"},   32'(fireComplete), 32'd0);
    if (scramble) begin
      chanEnable = '1;
      phaseDelay = '0;
      for (int i = 0; i < N_CH; i++) chargeTime[i*CT_W +: CT_W] = CT_W'(7);
      pulseCount = NP_W'(5);
      offTime    = '0;
      tick();
      check_eq({name, " still armed"}, 32'(busy), 32'd1);
    end
    GOGOGO_EXCLAMATION = 1'b1;
    tick();
    check_eq({name, " fire edge out"}, 32'(transducerOutput), 32'd0);
    for (int t = 1; t <= ncyc; t++) begin
      tick();
      check_eq($sformatf("%s out t=%0d", name, t),  32'(transducerOutput), 32'(exp_out(t)));
      check_eq($sformatf("%s fc t=%0d", name, t),   32'(fireComplete), 32'(t >= done_at));
      check_eq($sformatf("%s busy t=%0d", name, t), 32'(busy), 32'(t < done_at));
    end
    onYourMark = 1'b0; GOGOGO_EXCLAMATION = 1'b0;
    tick();
    check_all({name, " release"}, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; isActive = 1'b1; onYourMark = 1'b0; GOGOGO_EXCLAMATION = 1'b0;
    chanEnable = '0; phaseDelay = '0; chargeTime = '0; pulseCount = '0; offTime = '0;
    tick();
    tick();
    check_all("reset", '0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    tick();
    check_all("idle", '0, 1'b0, '0, 1'b0);

    // 1: two channels, single pulse
    set_cfg(3, 5, 0, 2, 0, 0, 0, 0, 4'b0011, 1, 0);
    run_fire("t1", 12, 10, 1'b0);

    // 2: burst of three, 4 high / 3 low, last channel finishes at k+19
    set_cfg(0, 4, 0, 0, 0, 0, 0, 0, 4'b0001, 3, 3);
    run_fire("t2", 22, 20, 1'b0);

    // pulseCount 0 acts as 1; ct=0 channel never rises
    set_cfg(2, 3, 4, 0, 0, 0, 0, 0, 4'b0011, 0, 5);
    run_fire("t2b", 9, 7, 1'b0);

    // 4: fire without arm is ignored
    onYourMark = 1'b0; GOGOGO_EXCLAMATION = 1'b1;
    tick(); tick(); tick();
    check_all("t4 gogo only", '0, 1'b0, '0, 1'b0);
    onYourMark = 1'b1;
    tick();
    check_all("t4 mark+gogo idle", '0, 1'b0, '0, 1'b0);
    onYourMark = 1'b0; GOGOGO_EXCLAMATION = 1'b0;
    tick();
    // values changed after arm must not affect the burst
    set_cfg(1, 2, 0, 0, 3, 1, 0, 0, 4'b0101, 2, 1);
    run_fire("t4", 10, 8, 1'b1);

    // 3: merged 12-cycle high interval trips at the 8th high cycle
    set_cfg(0, 0, 0, 0, 1, 6, 0, 0, 4'b0100, 2, 0);
    arm_and_fire();
    for (int t = 1; t <= 9; t++) begin
      tick();
      check_eq($sformatf("t3 out t=%0d", t),  32'(transducerOutput), 32'(exp_out(t)));
      check_eq($sformatf("t3 warn t=%0d", t), 32'(warning), (t >= 9) ? 32'h4 : 32'h0);
    end
    tick();
    check_all("t3 fault", '0, 1'b1, 4'b0100, 1'b0);
    GOGOGO_EXCLAMATION = 1'b0;
    tick();
    GOGOGO_EXCLAMATION = 1'b1;
    tick();
    tick();
    check_all("t3 fault holds", '0, 1'b1, 4'b0100, 1'b0);
    onYourMark = 1'b0; GOGOGO_EXCLAMATION = 1'b0;
    rst = 1'b1;
    tick();
    check_all("t3 rst", '0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    tick();

    // 5: abort by dropping GOGO mid-pulse
    set_cfg(0, 6, 0, 0, 0, 0, 0, 0, 4'b0001, 1, 0);
    arm_and_fire();
    tick(); tick(); tick();
    check_eq("t5 mid pulse", 32'(transducerOutput), 32'h1);
    GOGOGO_EXCLAMATION = 1'b0;
    tick();
    check_all("t5 abort", '0, 1'b0, '0, 1'b0);
    onYourMark = 1'b0;
    tick();
    check_eq("t5 idle busy", 32'(busy), 32'd0);
    // rst mid-FIRING
    arm_and_fire();
    tick(); tick(); tick();
    check_eq("t5b mid pulse", 32'(transducerOutput), 32'h1);
    rst = 1'b1;
    tick();
    check_all("t5 rst", '0, 1'b0, '0, 1'b0);
    rst = 1'b0; onYourMark = 1'b0; GOGOGO_EXCLAMATION = 1'b0;
    tick();

    // 6: isActive low during FIRING
    arm_and_fire();
    tick(); tick();
    check_eq("t6 firing", 32'(transducerOutput), 32'h1);
    isActive = 1'b0;
    tick();
    check_all("t6 inactive", '0, 1'b1, '0, 1'b0);
    tick();
    check_eq("t6 inactive fc hold", 32'(fireComplete), 32'd1);
    isActive = 1'b1; onYourMark = 1'b0; GOGOGO_EXCLAMATION = 1'b0;
    tick();
    check_eq("t6 reactivated fc", 32'(fireComplete), 32'd0);
    // a watchdog fault is also cleared by isActive low
    set_cfg(0, 0, 0, 0, 0, 0, 0, 10, 4'b1000, 1, 0);
    arm_and_fire();
    for (int t = 1; t <= 9; t++) tick();
    check_all("t6 fault", '0, 1'b1, 4'b1000, 1'b0);
    onYourMark = 1'b0; GOGOGO_EXCLAMATION = 1'b0;
    isActive = 1'b0;
    tick();
    check_all("t6 fault cleared", '0, 1'b1, '0, 1'b0);
    isActive = 1'b1;
    tick();
    check_eq("t6 ready fc", 32'(fireComplete), 32'd0);
    set_cfg(3, 5, 0, 2, 0, 0, 0, 0, 4'b0011, 1, 0);
    run_fire("t6 rerun", 12, 10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
